// File: rtl/gb_host.sv
// gb_host: ghostbus initiator. Turns a valid/ready command stream into
// single-cycle write strobes and fixed-latency reads, returning read data
// on a valid/ready response stream. One transaction outstanding at a time.
// Optional feature macro: GB_HOST_BURST_EN (multi-beat reads via cmd_len).
module gb_host #(
   parameter int unsigned AW     = 24,
   parameter int unsigned DW     = 32,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_we,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   input  logic [7:0]    cmd_len,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_last,
   output logic          busy,
   output logic          gb_clk,
   output logic [AW-1:0] gb_addr,
   output logic [DW-1:0] gb_dout,
   input  logic [DW-1:0] gb_din,
   output logic          gb_we
);

   localparam int unsigned LW = 4;
   localparam logic [LW-1:0] LAT_MAX = LW'(RD_LAT);

   typedef enum logic [2:0] {IDLE, WRITE, RADDR, RWAIT, RSP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [LW-1:0] lat_cnt;
   logic          cmd_fire;
   logic          rsp_fire;
   logic          lat_done;
   logic          beats_left;

   assign gb_clk   = clk;
   assign cmd_fire = cmd_valid && cmd_ready;
   assign rsp_fire = rsp_valid && rsp_ready;
   assign lat_done = (lat_cnt == LAT_MAX);

`ifdef GB_HOST_BURST_EN
   logic [7:0] beat_cnt;

   assign beats_left = (beat_cnt != 8'd0);

   // Remaining-beat counter for multi-beat reads
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= 8'd0;
      end else if (state == IDLE && cmd_fire && !cmd_we) begin
         beat_cnt <= cmd_len;
      end else if (state == RSP && rsp_fire && beats_left) begin
         beat_cnt <= beat_cnt - 8'd1;
      end
   end
`else
   logic unused_cmd_len;

   assign beats_left     = 1'b0;
   assign unused_cmd_len = ^cmd_len;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (cmd_fire) state_nxt = cmd_we ? WRITE : RADDR;
         WRITE: state_nxt = IDLE;
         RADDR: state_nxt = lat_done ? RSP : RWAIT;
         RWAIT: state_nxt = lat_done ? RSP : RWAIT;
         RSP:   if (rsp_fire) state_nxt = beats_left ? RADDR : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs; cmd_ready is additionally gated by reset
   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      gb_we     = 1'b0;
      rsp_valid = 1'b0;
      rsp_last  = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = !rst;
            busy      = 1'b0;
         end
         WRITE: gb_we = 1'b1;
         RSP: begin
            rsp_valid = 1'b1;
            rsp_last  = !beats_left;
         end
         default: ;
      endcase
   end

   // Bus address/data, latency counter and read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         gb_addr  <= '0;
         gb_dout  <= '0;
         rsp_data <= '0;
         lat_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  gb_addr <= cmd_addr;
                  lat_cnt <= '0;
                  if (cmd_we) gb_dout <= cmd_wdata;
               end
            end
            RADDR, RWAIT: begin
               if (lat_done) rsp_data <= gb_din;
               else          lat_cnt  <= lat_cnt + LW'(1);
            end
            RSP: begin
               if (rsp_fire && beats_left) begin
                  gb_addr <= gb_addr + AW'(1);
                  lat_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gb_host.sv
// tb_gb_host: directed + randomized bench for gb_host. Two instances share
// the command stimulus: dut_a with RD_LAT=2, dut_b with RD_LAT=0; "sel"
// chooses which one is active and observed.
module tb_gb_host;

   localparam int unsigned AW = 24;
   localparam int unsigned DW = 32;
   localparam logic [31:0] KEY = 32'hA5A5A5A5;
`ifdef GB_HOST_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          sel;
   logic          cmd_valid;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [7:0]    cmd_len;
   logic          rsp_ready;

   logic          a_cmd_ready, a_rsp_valid, a_rsp_last, a_busy, a_gb_clk, a_gb_we;
   logic [DW-1:0] a_rsp_data, a_gb_dout, a_gb_din;
   logic [AW-1:0] a_gb_addr;
   logic          b_cmd_ready, b_rsp_valid, b_rsp_last, b_busy, b_gb_clk, b_gb_we;
   logic [DW-1:0] b_rsp_data, b_gb_dout, b_gb_din;
   logic [AW-1:0] b_gb_addr;

   // Observed view of the selected instance
   logic          cmd_ready, rsp_valid, rsp_last, busy, gb_we;
   logic [DW-1:0] rsp_data, gb_dout;
   logic [AW-1:0] gb_addr;

   int unsigned cyc = 0;
   int unsigned sample_cyc = 32'hFFFF_FFFF;
   int unsigned total = 0;
   int unsigned passed = 0;
   int unsigned fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus slave model: correct data only in the one cycle the read must sample
   assign a_gb_din = (!sel && cyc == sample_cyc) ? (32'(a_gb_addr) ^ KEY) : ~(32'(a_gb_addr) ^ KEY);
   assign b_gb_din = ( sel && cyc == sample_cyc) ? (32'(b_gb_addr) ^ KEY) : ~(32'(b_gb_addr) ^ KEY);

   assign cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
   assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign rsp_last  = sel ? b_rsp_last  : a_rsp_last;
   assign busy      = sel ? b_busy      : a_busy;
   assign gb_we     = sel ? b_gb_we     : a_gb_we;
   assign rsp_data  = sel ? b_rsp_data  : a_rsp_data;
   assign gb_dout   = sel ? b_gb_dout   : a_gb_dout;
   assign gb_addr   = sel ? b_gb_addr   : a_gb_addr;

   gb_host #(.AW(AW), .DW(DW), .RD_LAT(2)) dut_a (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel), .rsp_data(a_rsp_data),
      .rsp_last(a_rsp_last), .busy(a_busy), .gb_clk(a_gb_clk), .gb_addr(a_gb_addr),
      .gb_dout(a_gb_dout), .gb_din(a_gb_din), .gb_we(a_gb_we)
   );

   gb_host #(.AW(AW), .DW(DW), .RD_LAT(0)) dut_b (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel), .rsp_data(b_rsp_data),
      .rsp_last(b_rsp_last), .busy(b_busy), .gb_clk(b_gb_clk), .gb_addr(b_gb_addr),
      .gb_dout(b_gb_dout), .gb_din(b_gb_din), .gb_we(b_gb_we)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single write; called in an IDLE cycle just after the falling edge
   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = addr; cmd_wdata = data;
      cmd_len = 8'($urandom);
      #1 check("wr_cmd_ready", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
      #1;
      check("wr_strobe", 64'(gb_we), 64'(1));
      check("wr_addr", 64'(gb_addr), 64'(addr));
      check("wr_dout", 64'(gb_dout), 64'(data));
      check("wr_no_rsp", 64'(rsp_valid), 64'(0));
      check("wr_ready_low", 64'(cmd_ready), 64'(0));
      @(negedge clk);
      #1;
      check("wr_strobe_end", 64'(gb_we), 64'(0));
      check("wr_no_rsp2", 64'(rsp_valid), 64'(0));
      check("wr_ready_back", 64'(cmd_ready), 64'(1));
      check("wr_addr_kept", 64'(gb_addr), 64'(addr));
      check("wr_dout_kept", 64'(gb_dout), 64'(data));
   endtask

   // Read (burst when enabled): beats at addr, addr+1, ... with random stalls
   task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input int unsigned max_stall);
      int unsigned   nb, lat_v, stall;
      logic [AW-1:0] a;
      logic [DW-1:0] exp_data;
      nb    = BURST ? int'(len) + 1 : 1;
      lat_v = sel ? 0 : 2;
      a     = addr;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = addr; cmd_len = len;
      cmd_wdata = $urandom;
      #1 check("rd_cmd_ready", 64'(cmd_ready), 64'(1));
      sample_cyc = cyc + 1 + lat_v;
      for (int b = 0; b < int'(nb); b++) begin
         @(negedge clk);
         cmd_valid = 1'b0; rsp_ready = 1'b0;
         #1;
         check("rd_addr", 64'(gb_addr), 64'(a));
         check("rd_we_low", 64'(gb_we), 64'(0));
         check("rd_no_early_rsp", 64'(rsp_valid), 64'(0));
         for (int i = 0; i < int'(lat_v); i++) begin
            @(negedge clk);
            #1;
            check("rd_wait_no_rsp", 64'(rsp_valid), 64'(0));
            check("rd_addr_held", 64'(gb_addr), 64'(a));
         end
         @(negedge clk);
         exp_data = 32'(a) ^ KEY;
         stall = $urandom_range(0, max_stall);
         for (int s = 0; s <= int'(stall); s++) begin
            #1;
            check("rsp_valid", 64'(rsp_valid), 64'(1));
            check("rsp_data", 64'(rsp_data), 64'(exp_data));
            check("rsp_last", 64'(rsp_last), 64'(b == int'(nb) - 1));
            check("rsp_busy", 64'(busy), 64'(1));
            check("rsp_ready_low", 64'(cmd_ready), 64'(0));
            rsp_ready = (s == int'(stall));
            if (s == int'(stall)) sample_cyc = cyc + 1 + lat_v;
            if (s < int'(stall)) @(negedge clk);
         end
         a = a + AW'(1);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check("rd_done_idle", 64'(busy), 64'(0));
      check("rd_done_no_rsp", 64'(rsp_valid), 64'(0));
      check("rd_done_ready", 64'(cmd_ready), 64'(1));
   endtask

   initial begin
      logic [AW-1:0] last_addr;
      logic [DW-1:0] last_data;
      rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_len = '0; rsp_ready = 1'b0;
      last_addr = '0; last_data = '0;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      check("rst_gb_addr", 64'(gb_addr), 64'(0));
      check("rst_gb_dout", 64'(gb_dout), 64'(0));
      check("rst_gb_we", 64'(gb_we), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_data", 64'(rsp_data), 64'(0));
      check("rst_rsp_last", 64'(rsp_last), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      #1 check("rst_release_ready", 64'(cmd_ready), 64'(1));
      @(negedge clk);

      // Directed cases
      do_write(24'h000010, 32'hCECEFACE);
      do_read(24'h100000, 8'd0, 0);
      check("rd_known_value", 64'(32'h0010_0000 ^ KEY), 64'(32'hA5B5A5A5));
      do_read(24'hFFFFFE, 8'd3, 2);

      // Randomized mix of writes and reads
      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 1) == 1) do_write(AW'($urandom), $urandom);
         else do_read(AW'($urandom), 8'($urandom_range(0, 3)), 3);
      end

      // Back-to-back writes with cmd_valid held high
      cmd_valid = 1'b1; cmd_we = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cmd_addr = AW'($urandom); cmd_wdata = $urandom;
         #1;
         check("b2b_ready", 64'(cmd_ready), 64'(i % 2 == 0));
         check("b2b_we", 64'(gb_we), 64'(i % 2 == 1));
         if (i % 2 == 1) begin
            check("b2b_addr", 64'(gb_addr), 64'(last_addr));
            check("b2b_dout", 64'(gb_dout), 64'(last_data));
         end else begin
            last_addr = cmd_addr; last_data = cmd_wdata;
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      #1;
      check("b2b_end_we", 64'(gb_we), 64'(0));
      check("b2b_end_ready", 64'(cmd_ready), 64'(1));
      @(negedge clk);

      // Reset while waiting on read latency of a 4-beat burst
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h123456; cmd_len = 8'd3;
      #1 check("mid_cmd_ready", 64'(cmd_ready), 64'(1));
      sample_cyc = 32'hFFFF_FFFF;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      #1 check("mid_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      #1 check("mid_rst_ready", 64'(cmd_ready), 64'(0));
      @(negedge clk);
      #1;
      check("mid_gb_addr", 64'(gb_addr), 64'(0));
      check("mid_gb_dout", 64'(gb_dout), 64'(0));
      check("mid_gb_we", 64'(gb_we), 64'(0));
      check("mid_rsp_valid", 64'(rsp_valid), 64'(0));
      check("mid_rsp_data", 64'(rsp_data), 64'(0));
      check("mid_rsp_last", 64'(rsp_last), 64'(0));
      check("mid_busy_rst", 64'(busy), 64'(0));
      rst = 1'b0;
      #1 check("mid_ready_after", 64'(cmd_ready), 64'(1));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         check("mid_no_rsp", 64'(rsp_valid), 64'(0));
         check("mid_no_we", 64'(gb_we), 64'(0));
         check("mid_idle", 64'(busy), 64'(0));
      end

      // Zero-latency instance
      sel = 1'b1;
      #1 check("lat0_ready", 64'(cmd_ready), 64'(1));
      do_read(24'h000ABC, 8'd0, 0);
      do_write(24'h00BEEF, 32'h1234_5678);
      for (int t = 0; t < 8; t++) begin
         if ($urandom_range(0, 1) == 1) do_write(AW'($urandom), $urandom);
         else do_read(AW'($urandom), 8'($urandom_range(0, 2)), 2);
      end
      do_read(24'hFFFFFF, 8'd1, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/gb_host.md
# gb_host

Ghostbus initiator: converts a valid/ready command stream into single-cycle ghostbus write strobes and fixed-latency reads. Read data returns on a valid/ready response stream. Sits above the decoded ghostbus tree and drives the `gb_*` ports consumed by every host-accessible module (registers, RAMs, `ghostbus_ext` bridges). One transaction is outstanding at a time; reads are not pipelined.

## Interface
Parameters:
- `AW`, 24, ghostbus address width.
- `DW`, 32, ghostbus data width.
- `RD_LAT`, 2, number of clock edges after the edge that launches `gb_addr` before `gb_din` is valid; legal range 0..15.

Ports:
- `clk`  in  1  single clock for host side and bus.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AW  start address.
- `cmd_wdata`  in  DW  write data; ignored for reads.
- `cmd_len`  in  8  read beats minus one (burst build only).
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  DW  captured `gb_din`.
- `rsp_last`  out  1  final beat of the read.
- `busy`  out  1  high whenever state is not IDLE.
- `gb_clk`  out  1  wire copy of `clk`.
- `gb_addr`  out  AW  bus address, registered.
- `gb_dout`  out  DW  bus write data, registered.
- `gb_din`  in  DW  bus read data.
- `gb_we`  out  1  write strobe, one cycle per write.

## Operation
- States: IDLE, WRITE, RADDR, RWAIT, RSP.
- `cmd_ready` is high only in IDLE and only while `rst` is low.
- **IDLE**, handshake:
  - Latch `cmd_addr` into `gb_addr`.
  - If `cmd_we`, latch `cmd_wdata` into `gb_dout` and go to WRITE; otherwise load the beat counter from `cmd_len` and go to RADDR.
- **WRITE**:
  - `gb_we`=1 for exactly this cycle, then IDLE.
  - No response is generated for writes.
- **RADDR/RWAIT**:
  - `gb_we`=0 and `gb_addr` is held.
  - A latency counter runs from 0 to `RD_LAT`.
  - `gb_din` is sampled into `rsp_data` on the edge ending the cycle where the counter equals `RD_LAT`; then go to RSP.
  - With `RD_LAT`=0, the sample is taken at the end of RADDR.
- **RSP**:
  - `rsp_valid`=1; `rsp_data` and `rsp_last` are held stable until `rsp_ready`.
  - On handshake, with beats remaining: decrement the counter, set `gb_addr`←`gb_addr`+1 modulo 2^AW (0xFFFFFF wraps to 0), and go to RADDR.
  - On handshake with no beats remaining: go to IDLE.
- `rsp_last` is high in RSP when the beat counter is 0.
- `gb_addr`/`gb_dout` keep their last values in IDLE. `gb_we`=0 in every state except WRITE.
- **Reset:**
  - An edge with `rst`=1 forces IDLE and sets `gb_addr`=0, `gb_dout`=0, `gb_we`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `busy`=0, `cmd_ready`=0.
  - `cmd_ready` rises in the first cycle after `rst` falls.
  - Reset mid-transaction drops the transaction: no strobe and no response are emitted afterward.
- `cmd_valid` in non-IDLE states is ignored. No command is lost, because `cmd_ready` is low in those states.

## Timing
- Command handshake in cycle N.
- **Write:** `gb_we`=1 in cycle N+1; `cmd_ready` high again in N+2, so peak write rate is one write per 2 cycles.
- **Read:**
  - `gb_addr` valid from cycle N+1.
  - `gb_din` is sampled at the end of cycle N+1+`RD_LAT`.
  - `rsp_valid` is high from cycle N+2+`RD_LAT`.
- **Burst:** each subsequent beat starts its address cycle the cycle after the response handshake. The beat period is `RD_LAT`+2 cycles when `rsp_ready` is held high.
- `rsp_ready` held low stalls indefinitely in RSP; the bus is idle during the stall.

## Configuration
- `GB_HOST_BURST_EN` defined: `cmd_len` is honoured, and a read returns `cmd_len`+1 beats at incrementing addresses.
- `GB_HOST_BURST_EN` undefined: `cmd_len` is ignored and the beat counter logic is removed. Every read returns exactly one beat, with `rsp_last`=1 whenever `rsp_valid`=1.

## Test plan
- Write, addr 0x000010, data 0xCECEFACE -> `gb_we` high exactly one cycle (N+1) with `gb_addr`=0x000010, `gb_dout`=0xCECEFACE; `rsp_valid` never rises.
- Read with `RD_LAT`=2, model returning addr^0xA5A5A5A5 -> `rsp_valid` at N+4 with `rsp_data`=0xA5B5A5A5 for addr 0x100000 (0x100000^0xA5A5A5A5), `rsp_last`=1.
- Burst build, read addr 0xFFFFFE, `cmd_len`=3, `rsp_ready` toggling -> 4 beats from addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; `rsp_last` only on the 4th beat; `rsp_data` stable while stalled.
- `RD_LAT`=0 read -> `gb_din` sampled in the same cycle as the address; `rsp_valid` at N+2.
- `rst` asserted during RWAIT of a 4-beat burst -> all outputs at reset values after that edge; no further `rsp_valid`; `cmd_ready`=1 the cycle after `rst` falls.
- Back-to-back writes with `cmd_valid` held high -> accepts every 2nd cycle; exactly one `gb_we` pulse per accepted command.
